y86_pipe_ctrl: RTL
==================

# y86_pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. Each cycle it reads stage icodes, register IDs, branch outcome and stage status, and drives stall/bubble controls for the F, D, E, M and W pipeline registers plus the condition-code write enable. A run-state machine handles post-reset pipeline fill, exception drain and the final stop. Saturating performance counters are exported for the top level and testbench.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- FILL_CYCLES, 2, cycles of forced flush after reset release (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- D_icode  in  4  icode in D register
- d_srcA, d_srcB  in  4 each  decode source register IDs (0xF = none)
- E_icode  in  4  icode in E register
- E_dstM  in  4  E-stage memory destination register ID
- e_Cnd  in  1  execute branch/cmov condition
- M_icode  in  4  icode in M register
- m_stat  in  3  M-stage status after memory access
- W_icode  in  4  icode in W register
- W_stat  in  3  W-stage status
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_bubble, W_stall  out  1 each  pipeline register controls
- set_cc  out  1  CC write enable in execute
- halted  out  1  pipeline stopped
- cpu_stat  out  3  architectural status
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Encodings: icode HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B. stat AOK=1, HLT=2, ADR=3, INS=4. A bubble is NOP with stat AOK.
- Hazard terms:
  - lu (load-use) = E_icode∈{MRMOV,POP} and E_dstM≠0xF and E_dstM∈{d_srcA,d_srcB}
  - rt (ret in flight) = RET∈{D_icode,E_icode,M_icode}
  - mp (mispredict) = E_icode==JXX and !e_Cnd
  - mx = m_stat∈{HLT,ADR,INS}
  - wx = W_stat∈{HLT,ADR,INS}
- States: FILL, RUN, DRAIN, STOP.
- FILL:
  - Outputs: F_stall=1; D_bubble=E_bubble=M_bubble=W_bubble=1; everything else 0.
  - A fill counter runs FILL_CYCLES cycles, then the FSM moves to RUN.
- RUN:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (!lu & rt)
  - E_bubble = mp | lu
  - M_bubble = mx | wx
  - W_stall = wx
  - set_cc = (E_icode==OPQ) & !mx & !wx
  - W_bubble = 0
  - Never assert both D_stall and D_bubble.
- RUN transitions: wx → STOP (has priority over mx); else mx → DRAIN; else stay.
- DRAIN:
  - F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, set_cc=0, W_stall=wx.
  - Exits to STOP on wx.
  - If !wx for 2 consecutive cycles (exception was cancelled), return to RUN.
- STOP:
  - F_stall=1, W_stall=1, D_bubble=E_bubble=M_bubble=1, set_cc=0, halted=1.
  - Absorbing; only rst leaves STOP.
- cpu_stat:
  - AOK in FILL/RUN/DRAIN.
  - In STOP, the W_stat value registered on the entry cycle, held until reset.
- Counters: all saturate at 2^CNT_W−1 and hold. None count in FILL or STOP.
  - cyc_cnt: +1 every RUN or DRAIN cycle.
  - ret_cnt: +1 when state is RUN/DRAIN, W_stat==AOK and W_icode≠NOP.
  - stall_cnt: +1 on RUN cycles with F_stall=1.
  - flush_cnt: +1 on RUN cycles with mp=1.

## Timing
- Reset (async, immediate):
  - state=FILL, fill counter=0, all counters 0, cpu_stat=AOK, halted=0.
  - Reset-state outputs: F_stall=1, all bubbles 1, D_stall=0, W_stall=0, set_cc=0.
- Control outputs are combinational from the current state and inputs. They are valid in the same cycle, before the next rising edge.
- State, counters and cpu_stat update on the rising edge.
- The first RUN cycle is edge FILL_CYCLES after rst deasserts.
- halted rises on the edge after the first cycle with wx in RUN or DRAIN.
- Reset mid-operation (any state): same immediate reset values; re-enter FILL.
- Simultaneous mp & lu: D_stall=1, D_bubble=1 is illegal. Resolution: mp drops the load-use stall, since the mispredicted path is squashed. RUN therefore uses D_stall = lu & !mp, and F_stall still includes lu.
- Simultaneous mp & rt (RET in D): F_stall=1, D_bubble=1, E_bubble=1.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 in RUN → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt 0→1.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=9 → D_bubble=1, E_bubble=1, F_stall=1, D_stall=0; flush_cnt +1.
- Ret: D_icode=9 for 1 cycle, then E_icode=9, then M_icode=9 → F_stall=1 and D_bubble=1 on each of those 3 cycles; 0 on the 4th cycle.
- Halt drain: m_stat=2 one cycle, then W_stat=2 → DRAIN for 1 cycle with M_bubble=1, then STOP; halted=1 and cpu_stat=2, held for 10+ cycles; counters frozen.
- Reset mid-run: assert rst between edges while ret_cnt=5 in RUN → outputs go to reset values immediately; after release, 2 FILL cycles then RUN; set_cc=0 throughout FILL.
- Saturation: CNT_W=4, 20 RUN cycles with retiring OPQ instructions → cyc_cnt and ret_cnt hold at 15; no wrap to 0.

Source files
------------

// File: rtl/y86_pipe_ctrl_if.sv
// Stage-status inputs and pipeline-register controls shared between the
// Y86-64 pipeline control unit (master) and the datapath (slave).
interface y86_pipe_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [3:0]       D_icode;
   logic [3:0]       d_srcA;
   logic [3:0]       d_srcB;
   logic [3:0]       E_icode;
   logic [3:0]       E_dstM;
   logic             e_Cnd;
   logic [3:0]       M_icode;
   logic [2:0]       m_stat;
   logic [3:0]       W_icode;
   logic [2:0]       W_stat;

   logic             F_stall;
   logic             D_stall;
   logic             D_bubble;
   logic             E_bubble;
   logic             M_bubble;
   logic             W_bubble;
   logic             W_stall;
   logic             set_cc;
   logic             halted;
   logic [2:0]       cpu_stat;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] ret_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_bubble,
             W_stall, set_cc, halted, cpu_stat,
             cyc_cnt, ret_cnt, stall_cnt, flush_cnt
   );

   modport slave (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
             M_icode, m_stat, W_icode, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_bubble,
             W_stall, set_cc, halted, cpu_stat,
             cyc_cnt, ret_cnt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/y86_pipe_ctrl.sv
// Y86-64 pipeline control: combinational stall/bubble decode per run state,
// FILL/RUN/DRAIN/STOP sequencing and saturating performance counters.
module y86_pipe_ctrl #(
   parameter int CNT_W       = 32,
   parameter int FILL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   y86_pipe_ctrl_if.master bus
);
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_POP   = 4'hB;
   localparam logic [3:0] R_NONE  = 4'hF;
   localparam logic [2:0] S_AOK   = 3'd1;
   localparam logic [2:0] S_HLT   = 3'd2;
   localparam logic [2:0] S_ADR   = 3'd3;
   localparam logic [2:0] S_INS   = 3'd4;

   localparam int              FILL_W    = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);

   typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_DRAIN, ST_STOP} state_t;

   state_t             state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               drain_q, drain_d;
   logic [2:0]         cpu_stat_q, cpu_stat_d;
   logic [CNT_W-1:0]   cyc_q, ret_q, stall_q, flush_q;

   logic lu, rt, mp, mx, wx, active;

   assign lu = (bus.E_icode == I_MRMOV || bus.E_icode == I_POP) && (bus.E_dstM != R_NONE)
               && (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
   assign rt = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
   assign mp = (bus.E_icode == I_JXX) && !bus.e_Cnd;
   assign mx = (bus.m_stat == S_HLT) || (bus.m_stat == S_ADR) || (bus.m_stat == S_INS);
   assign wx = (bus.W_stat == S_HLT) || (bus.W_stat == S_ADR) || (bus.W_stat == S_INS);
   assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_comb begin
      state_d      = state_q;
      fill_d       = fill_q;
      drain_d      = drain_q;
      cpu_stat_d   = cpu_stat_q;
      bus.F_stall  = 1'b0;
      bus.D_stall  = 1'b0;
      bus.D_bubble = 1'b0;
      bus.E_bubble = 1'b0;
      bus.M_bubble = 1'b0;
      bus.W_bubble = 1'b0;
      bus.W_stall  = 1'b0;
      bus.set_cc   = 1'b0;
      case (state_q)
         ST_FILL: begin
            bus.F_stall  = 1'b1;
            bus.D_bubble = 1'b1;
            bus.E_bubble = 1'b1;
            bus.M_bubble = 1'b1;
            bus.W_bubble = 1'b1;
            if (fill_q == FILL_LAST) begin
               state_d = ST_RUN;
               fill_d  = '0;
            end else begin
               fill_d = fill_q + FILL_W'(1);
            end
         end
         ST_RUN: begin
            // A mispredict squashes the path, so it overrides the load-use stall in D.
            bus.F_stall  = lu | rt;
            bus.D_stall  = lu & !mp;
            bus.D_bubble = mp | (!lu & rt);
            bus.E_bubble = mp | lu;
            bus.M_bubble = mx | wx;
            bus.W_stall  = wx;
            bus.set_cc   = (bus.E_icode == I_OPQ) & !mx & !wx;
            if (wx) begin
               state_d    = ST_STOP;
               cpu_stat_d = bus.W_stat;
            end else if (mx) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            bus.F_stall  = 1'b1;
            bus.D_bubble = 1'b1;
            bus.E_bubble = 1'b1;
            bus.M_bubble = 1'b1;
            bus.W_stall  = wx;
            if (wx) begin
               state_d    = ST_STOP;
               cpu_stat_d = bus.W_stat;
            end else if (drain_q) begin
               state_d = ST_RUN;
               drain_d = 1'b0;
            end else begin
               drain_d = 1'b1;
            end
         end
         default: begin
            bus.F_stall  = 1'b1;
            bus.W_stall  = 1'b1;
            bus.D_bubble = 1'b1;
            bus.E_bubble = 1'b1;
            bus.M_bubble = 1'b1;
         end
      endcase
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_FILL;
         fill_q     <= '0;
         drain_q    <= 1'b0;
         cpu_stat_q <= S_AOK;
         cyc_q      <= '0;
         ret_q      <= '0;
         stall_q    <= '0;
         flush_q    <= '0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         drain_q    <= drain_d;
         cpu_stat_q <= cpu_stat_d;
         cyc_q      <= sat_inc(cyc_q, active);
         ret_q      <= sat_inc(ret_q, active && (bus.W_stat == S_AOK) && (bus.W_icode != I_NOP));
         stall_q    <= sat_inc(stall_q, (state_q == ST_RUN) && bus.F_stall);
         flush_q    <= sat_inc(flush_q, (state_q == ST_RUN) && mp);
      end
   end

   assign bus.halted    = (state_q == ST_STOP);
   assign bus.cpu_stat  = (state_q == ST_STOP) ? cpu_stat_q : S_AOK;
   assign bus.cyc_cnt   = cyc_q;
   assign bus.ret_cnt   = ret_q;
   assign bus.stall_cnt = stall_q;
   assign bus.flush_cnt = flush_q;
endmodule
